// File: rtl/onehot_decoder_pending_pkg.sv
// Shared definitions for the one-hot decoder with sticky pending capture.
// Holds the index width, the decoded line count and the index -> one-hot
// decode function. The encoder bench reuses decode() for its reference model.
package onehot_decoder_pending_pkg;

  localparam int DEC_IDX_W = 3;
  localparam int DEC_N     = 1 << DEC_IDX_W;

  // Index to one-hot; exactly one bit of the result is set.
  function automatic logic [DEC_N-1:0] decode(input logic [DEC_IDX_W-1:0] idx);
    logic [DEC_N-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/onehot_decoder_pending_pending_bit_cell.sv
// One line of pending/overflow state.
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   set      - decoded event for this line this cycle
//   ack      - downstream acknowledge for this line
//   ovf_clr  - clears the overflow flag
//   pending  - sticky: event seen, not yet acknowledged
//   overflow - sticky: event arrived while already pending
module pending_bit_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic ack,
  input  logic ovf_clr,
  output logic pending,
  output logic overflow
);

  logic r_pending;
  logic r_overflow;

  // A set always wins over ack/ovf_clr so no event is lost. A set that meets
  // an ack in the same cycle consumes the ack and is not an overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_pending  <= set | (r_pending & ~ack);
      r_overflow <= (set & r_pending & ~ack) | (r_overflow & ~ovf_clr);
    end
  end

  assign pending  = r_pending;
  assign overflow = r_overflow;

endmodule

// File: rtl/onehot_decoder_pending.sv
// Registered 3-to-8 decoder with sticky per-line pending capture.
// Consumes an encoder's {valid, index} pair and regenerates a one-hot pulse,
// while each decoded event also latches a pending bit until acknowledged.
// Ports:
//   clk         - rising-edge clock
//   rst_n       - asynchronous active-low reset
//   in_valid    - encoded index valid this cycle
//   in_idx      - encoded index (ignored when in_valid=0)
//   ack         - per-line acknowledge, clears matching pending bit
//   ovf_clr     - clears all overflow bits
//   out_onehot  - registered one-hot decode, one-cycle pulse
//   out_strobe  - registered copy of in_valid
//   pending     - sticky pending bits
//   overflow    - sticky: event arrived on a line already pending
//   any_pending - OR of pending
module onehot_decoder_pending
  import onehot_decoder_pending_pkg::*;
#(
  parameter int IDX_W = DEC_IDX_W,
  parameter int N     = DEC_N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  input  logic [N-1:0]     ack,
  input  logic             ovf_clr,
  output logic [N-1:0]     out_onehot,
  output logic             out_strobe,
  output logic [N-1:0]     pending,
  output logic [N-1:0]     overflow,
  output logic             any_pending
);

  // The line count is tied to the index width; other combinations are illegal.
  if (IDX_W != DEC_IDX_W || N != DEC_N) begin : g_bad_params
    $error("onehot_decoder_pending: IDX_W/N must match the package (N = 2**IDX_W)");
  end

  logic [N-1:0] w_set;
  logic [N-1:0] w_pending;
  logic [N-1:0] w_overflow;
  logic [N-1:0] r_onehot_p1;
  logic         r_vld_p1;

  // in_idx may be X while in_valid is low; the mux keeps it out of the datapath.
  assign w_set = in_valid ? decode(in_idx) : '0;

  // Stage p0 -> p1: one-cycle registered decode pulse, no hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_onehot_p1 <= '0;
      r_vld_p1    <= 1'b0;
    end else begin
      r_onehot_p1 <= w_set;
      r_vld_p1    <= in_valid;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_cell
    pending_bit_cell u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .set      (w_set[gi]),
      .ack      (ack[gi]),
      .ovf_clr  (ovf_clr),
      .pending  (w_pending[gi]),
      .overflow (w_overflow[gi])
    );
  end

  assign out_onehot  = r_onehot_p1;
  assign out_strobe  = r_vld_p1;
  assign pending     = w_pending;
  assign overflow    = w_overflow;
  assign any_pending = |w_pending;

endmodule
